// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: queues fetch predictions, checks them against resolved outcomes,
// drives fetch redirect and the BTB write port. Optional statistics counters under BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [31:0]      push_pc,
    input  logic             push_taken,
    input  logic [31:0]      push_target,
    output logic             full,
    output logic             empty,
    input  logic             resolve,
    input  logic [31:0]      resolve_pc,
    input  logic             resolve_taken,
    input  logic [31:0]      resolve_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             WEN,
    output logic [31:0]      pc_w,
    output logic             taken_w,
    output logic [31:0]      target_w,
    output logic             err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        RUN,
        REDIRECT
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   q_pc     [DEPTH];
    logic          q_taken  [DEPTH];
    logic [31:0]   q_target [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;

    logic [31:0] hp, htg;
    logic        ht;
    logic        vld_p0;
    logic        mispred_p0;
    logic        push_ok;
    logic        err_set;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Stage p0: head lookup, mispredict detection and push acceptance
    always_comb begin
        hp         = q_pc[rd_q];
        ht         = q_taken[rd_q];
        htg        = q_target[rd_q];
        vld_p0     = resolve && !empty;
        mispred_p0 = 1'b0;
        if (vld_p0) begin
            mispred_p0 = (ht != resolve_taken) ||
                         (ht && resolve_taken && (htg != resolve_target));
        end
        // A push concurrent with a mispredict or during REDIRECT is wrong-path, dropped quietly.
        push_ok = push && (state_q == RUN) && !mispred_p0 && (!full || vld_p0);
        err_set = (push && (state_q == RUN) && !mispred_p0 && full && !vld_p0) ||
                  (resolve && empty) ||
                  (vld_p0 && (hp != resolve_pc));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mispred_p0) state_d = REDIRECT;
            REDIRECT: state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            q_pc[wr_q]     <= push_pc;
            q_taken[wr_q]  <= push_taken;
            q_target[wr_q] <= push_target;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (mispred_p0) begin
            rd_q    <= wr_q;
            count_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + PW'(1);
            if (vld_p0)  rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(vld_p0);
        end
    end

    // Stage p1: registered BTB update, redirect and error flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WEN         <= 1'b0;
            pc_w        <= '0;
            taken_w     <= 1'b0;
            target_w    <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            err         <= 1'b0;
        end else begin
            WEN      <= vld_p0;
            redirect <= mispred_p0;
            if (vld_p0) begin
                pc_w     <= resolve_pc;
                taken_w  <= resolve_taken;
                target_w <= resolve_target;
            end
            if (mispred_p0) begin
                redirect_pc <= resolve_taken ? resolve_target : resolve_pc + 32'd4;
            end
            if (err_set) err <= 1'b1;
        end
    end

`ifdef BRU_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (vld_p0)     branch_cnt  <= sat_inc(branch_cnt);
            if (mispred_p0) mispred_cnt <= sat_inc(mispred_cnt);
        end
    end
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; counter expectations follow BRU_STATS_EN.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             push;
    logic [31:0]      push_pc;
    logic             push_taken;
    logic [31:0]      push_target;
    logic             full, empty;
    logic             resolve;
    logic [31:0]      resolve_pc;
    logic             resolve_taken;
    logic [31:0]      resolve_target;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             WEN;
    logic [31:0]      pc_w;
    logic             taken_w;
    logic [31:0]      target_w;
    logic             err;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    int errors = 0;
    int checks = 0;
    int nb = 0;
    int nm = 0;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .push(push), .push_pc(push_pc), .push_taken(push_taken), .push_target(push_target),
        .full(full), .empty(empty),
        .resolve(resolve), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .WEN(WEN), .pc_w(pc_w), .taken_w(taken_w), .target_w(target_w),
        .err(err), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tg);
        push = v; push_pc = pc; push_taken = t; push_target = tg;
    endtask

    task automatic set_res(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tg);
        resolve = v; resolve_pc = pc; resolve_taken = t; resolve_target = tg;
    endtask

    task automatic idle();
        set_push(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_bcnt"}, 32'(branch_cnt),  STATS ? 32'(nb) : 32'h0);
        chk({tag, "_mcnt"}, 32'(mispred_cnt), STATS ? 32'(nm) : 32'h0);
    endtask

    initial begin
        RST = 1'b1;
        idle();
        tick();
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_wen", 32'(WEN), 32'h0);
        chk("rst_redir", 32'(redirect), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_pcw", pc_w, 32'h0);
        chk("rst_rpc", redirect_pc, 32'h0);
        chk_cnt("rst");
        RST = 1'b0;
        tick();

        // correctly predicted taken branch
        set_push(1'b1, 32'h40, 1'b1, 32'h80);
        tick();
        idle();
        chk("t1_notempty", 32'(empty), 32'h0);
        set_res(1'b1, 32'h40, 1'b1, 32'h80);
        tick();
        idle();
        nb++;
        chk("t1_wen", 32'(WEN), 32'h1);
        chk("t1_pcw", pc_w, 32'h40);
        chk("t1_takw", 32'(taken_w), 32'h1);
        chk("t1_tgw", target_w, 32'h80);
        chk("t1_redir", 32'(redirect), 32'h0);
        chk("t1_empty", 32'(empty), 32'h1);
        tick();
        chk("t1_wen_off", 32'(WEN), 32'h0);

        // predicted not-taken, actually taken
        set_push(1'b1, 32'h10, 1'b0, 32'h0);
        tick();
        set_push(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b1, 32'h10, 1'b1, 32'h100);
        tick();
        idle();
        nb++; nm++;
        chk("t2_redir", 32'(redirect), 32'h1);
        chk("t2_rpc", redirect_pc, 32'h100);
        chk("t2_wen", 32'(WEN), 32'h1);
        chk_cnt("t2");
        tick();
        chk("t2_redir_off", 32'(redirect), 32'h0);

        // mispredict flushes queue; same-cycle and REDIRECT-cycle pushes dropped
        set_push(1'b1, 32'h20, 1'b1, 32'h200);
        tick();
        set_push(1'b1, 32'h24, 1'b0, 32'h0);
        tick();
        set_push(1'b1, 32'h28, 1'b0, 32'h0);
        set_res(1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        nb++; nm++;
        set_res(1'b0, 32'h0, 1'b0, 32'h0);
        set_push(1'b1, 32'h2C, 1'b0, 32'h0);
        chk("t3_redir", 32'(redirect), 32'h1);
        chk("t3_rpc", redirect_pc, 32'h24);
        chk("t3_flush", 32'(empty), 32'h1);
        tick();
        idle();
        chk("t3_redir_drop", 32'(empty), 32'h1);
        chk("t3_noerr", 32'(err), 32'h0);
        chk_cnt("t3");

        // resolve against an empty queue
        set_res(1'b1, 32'h50, 1'b1, 32'h60);
        tick();
        idle();
        chk("t5_err", 32'(err), 32'h1);
        chk("t5_wen", 32'(WEN), 32'h0);
        chk("t5_redir", 32'(redirect), 32'h0);
        chk_cnt("t5");

        RST = 1'b1;
        tick();
        RST = 1'b0;
        nb = 0; nm = 0;
        chk("t4_err_clr", 32'(err), 32'h0);

        // fill, overflow, push+resolve when full
        for (int i = 0; i < DEPTH; i++) begin
            set_push(1'b1, 32'h100 + 32'(4 * i), 1'b0, 32'h0);
            tick();
        end
        idle();
        chk("t4_full", 32'(full), 32'h1);
        chk("t4_err0", 32'(err), 32'h0);
        set_push(1'b1, 32'h110, 1'b0, 32'h0);
        tick();
        idle();
        chk("t4_ovf_err", 32'(err), 32'h1);
        chk("t4_ovf_full", 32'(full), 32'h1);
        set_push(1'b1, 32'h114, 1'b0, 32'h0);
        set_res(1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        idle();
        nb++;
        chk("t4_pr_full", 32'(full), 32'h1);
        chk("t4_pr_pcw", pc_w, 32'h100);
        chk("t4_pr_redir", 32'(redirect), 32'h0);
        chk("t4_pr_err", 32'(err), 32'h1);
        set_res(1'b1, 32'h104, 1'b0, 32'h0); tick(); nb++;
        chk("t4_d1", pc_w, 32'h104);
        set_res(1'b1, 32'h108, 1'b0, 32'h0); tick(); nb++;
        chk("t4_d2", pc_w, 32'h108);
        set_res(1'b1, 32'h10C, 1'b0, 32'h0); tick(); nb++;
        chk("t4_d3", pc_w, 32'h10C);
        set_res(1'b1, 32'h114, 1'b0, 32'h0); tick(); nb++;
        idle();
        chk("t4_d4", pc_w, 32'h114);
        chk("t4_drained", 32'(empty), 32'h1);
        chk_cnt("t4");

        // asynchronous reset mid-stream with three entries queued
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'h200 + 32'(4 * i), 1'b0, 32'h0);
            tick();
        end
        idle();
        chk("t6_pre", 32'(empty), 32'h0);
        #2;
        RST = 1'b1;
        #1;
        nb = 0; nm = 0;
        chk("t6_empty", 32'(empty), 32'h1);
        chk("t6_err", 32'(err), 32'h0);
        chk("t6_wen", 32'(WEN), 32'h0);
        chk_cnt("t6");
        tick();
        RST = 1'b0;

        // pointer wrap with interleaved resolves
        set_push(1'b1, 32'h300, 1'b0, 32'h0); tick();
        set_push(1'b1, 32'h304, 1'b1, 32'h400); tick();
        set_push(1'b1, 32'h308, 1'b0, 32'h0); tick();
        set_push(1'b1, 32'h30C, 1'b0, 32'h0);
        set_res(1'b1, 32'h300, 1'b0, 32'h0); tick(); nb++;
        chk("t7_w0", pc_w, 32'h300);
        set_push(1'b1, 32'h310, 1'b1, 32'h500);
        set_res(1'b1, 32'h304, 1'b1, 32'h400); tick(); nb++;
        chk("t7_w1", pc_w, 32'h304);
        chk("t7_w1_tg", target_w, 32'h400);
        set_push(1'b1, 32'h314, 1'b0, 32'h0);
        set_res(1'b1, 32'h308, 1'b0, 32'h0); tick(); nb++;
        chk("t7_w2", pc_w, 32'h308);
        set_push(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b1, 32'h30C, 1'b0, 32'h0); tick(); nb++;
        chk("t7_w3", pc_w, 32'h30C);
        set_res(1'b1, 32'h310, 1'b1, 32'h500); tick(); nb++;
        chk("t7_w4", pc_w, 32'h310);
        set_res(1'b1, 32'h314, 1'b0, 32'h0); tick(); nb++;
        idle();
        chk("t7_w5", pc_w, 32'h314);
        chk("t7_redir", 32'(redirect), 32'h0);
        chk("t7_err", 32'(err), 32'h0);
        chk("t7_empty", 32'(empty), 32'h1);

        // PC mismatch flags err but still updates with resolve values
        set_push(1'b1, 32'h600, 1'b0, 32'h0); tick();
        set_push(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b1, 32'h604, 1'b0, 32'h0); tick(); nb++;
        idle();
        chk("t8_err", 32'(err), 32'h1);
        chk("t8_pcw", pc_w, 32'h604);
        chk("t8_wen", 32'(WEN), 32'h1);

        // fall-through restart address wraps at 2^32
        set_push(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h8); tick();
        set_push(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0); tick(); nb++; nm++;
        idle();
        chk("t9_redir", 32'(redirect), 32'h1);
        chk("t9_rpc", redirect_pc, 32'h0);
        chk("t9_takw", 32'(taken_w), 32'h0);
        chk_cnt("t9");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolves branch predictions against actual outcomes; it is the producer of the BTB write port.
- Fetch pushes each prediction (pc, taken, target) into a small in-order queue.
- On resolution, the unit:
  - pops the oldest prediction,
  - detects a mispredict,
  - drives the fetch redirect and squashes wrong-path queue entries,
  - issues the BTB update (pc_w/taken_w/target_w/WEN).

Parameters:
- DEPTH, 4, in-flight prediction queue entries (power of 2, >=2)
- CNT_W, 16, width of statistics counters

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- push  in  1  fetch pushes a prediction this cycle
- push_pc  in  32  PC of the predicted branch
- push_taken  in  1  predicted direction
- push_target  in  32  predicted target
- full  out  1  queue holds DEPTH entries
- empty  out  1  queue holds 0 entries
- resolve  in  1  oldest branch resolved this cycle
- resolve_pc  in  32  PC of resolved branch
- resolve_taken  in  1  actual direction
- resolve_target  in  32  actual taken target
- redirect  out  1  one-cycle pulse: fetch must restart
- redirect_pc  out  32  restart address
- WEN  out  1  one-cycle pulse: BTB update
- pc_w  out  32  BTB update PC
- taken_w  out  1  BTB update direction
- target_w  out  32  BTB update target
- err  out  1  sticky protocol error
- branch_cnt  out  CNT_W  resolved branches
- mispred_cnt  out  CNT_W  mispredicted branches

Behaviour:
- Reset (RST=1, asynchronous):
  - queue empty, state RUN.
  - Output values: redirect=0, redirect_pc=0, WEN=0, pc_w=0, taken_w=0, target_w=0, err=0, counters=0.
  - empty=1, full=0.
  - Reset mid-operation discards all entries and any pending pulse.
- Queue:
  - circular buffer with rd/wr pointers and a count of width $clog2(DEPTH)+1.
  - full = (count==DEPTH); empty = (count==0).
  - Pointers wrap modulo DEPTH.
- Push accept rule: push is accepted iff all of the following hold:
  - state==RUN,
  - no mispredict this cycle,
  - (!full or pop this cycle).
- Push in the REDIRECT state, or in the cycle a mispredict is detected, is silently dropped (wrong path); this is not an error.
- Push while full without a same-cycle pop is dropped and sets err.
- Resolve:
  - On resolve=1 with !empty, pop the head entry (hp, ht, htg).
  - Resolve with empty queue: no pop, no WEN, no redirect; sets err.
  - hp != resolve_pc sets err; resolution still proceeds using the resolve_* values.
- Mispredict condition: (ht != resolve_taken) or (ht & resolve_taken & htg != resolve_target).
- Registered outputs, latency 1: on the edge after a valid resolve:
  - WEN=1, pc_w=resolve_pc, taken_w=resolve_taken, target_w=resolve_target (every resolved branch updates the BTB).
  - On mispredict: redirect=1, redirect_pc = resolve_taken ? resolve_target : resolve_pc+4 (32-bit wrap).
  - All pulses are deasserted the following cycle unless a new resolve occurs.
- Mispredict also has these effects at the same edge:
  - the queue is flushed (count=0, rd=wr) and the same-cycle push is dropped,
  - state moves RUN->REDIRECT.
- State REDIRECT lasts exactly one cycle (the cycle redirect=1), then returns to RUN.
- Resolve while in REDIRECT is processed normally against the (empty) queue, so it sets err.
- Simultaneous push+resolve without mispredict: both occur, count unchanged; legal when full.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined:
  - branch_cnt increments on each valid resolve.
  - mispred_cnt increments on each mispredict.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: no counter flops; branch_cnt and mispred_cnt are tied to 0.

Test Plan:
- Reset, then push pc=0x40 taken=1 target=0x80, then resolve pc=0x40 taken=1 target=0x80 -> next cycle WEN=1, pc_w=0x40, taken_w=1, target_w=0x80, redirect=0, empty=1.
- Push pc=0x10 taken=0, resolve pc=0x10 taken=1 target=0x100 -> redirect=1, redirect_pc=0x100, WEN=1; mispred_cnt=1 under BRU_STATS_EN.
- Push pc=0x20 taken=1 target=0x200 and pc=0x24; resolve pc=0x20 taken=0 while pushing 0x28 -> redirect_pc=0x24, queue flushed (empty=1), push 0x28 dropped; a push next cycle (REDIRECT) is also dropped.
- Push DEPTH entries -> full=1; 5th push alone -> dropped, err=1; push+resolve together when full -> count stays DEPTH, err unchanged.
- Resolve on an empty queue -> err=1, WEN=0, redirect=0; assert RST mid-stream with 3 entries queued -> empty=1, err=0, counters=0 immediately (asynchronous).
- Push 6 entries with interleaved non-mispredicting resolves (pointer wrap at DEPTH=4) -> pc_w sequence matches push order exactly.
